muldiv_unit: RTL

- Iterative 32-bit multiply/divide unit in the execute stage, alongside the ALU; takes the same a/b operands from the ID/EX operand path.
- Owns the HI/LO architectural registers (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
- Its hi/lo outputs feed the execute-stage result select (MFHI/MFLO) downstream of the ALU.
- busy drives the pipeline stall.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_if.sv | 31 +++
 rtl/muldiv_unit_cond_negate_64b.sv | 8 +
 rtl/muldiv_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and sizes for the iterative multiply/divide unit.
package muldiv_pkg;
  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_e;
endpackage

// File: rtl/muldiv_if.sv
// Execute-stage port bundle between the pipeline and the multiply/divide unit.
interface muldiv_if;
  import muldiv_pkg::*;

  // start is taken only while busy is low and flush is low; the op then owns the
  // unit until done pulses (or a flush), and busy stalls the pipeline meanwhile.
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  muldiv_state_e    dbg_state;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo, dbg_state
  );
endinterface

// File: rtl/muldiv_unit_cond_negate_64b.sv
// Conditional two's-complement negate, shared by operand abs and result sign fix.
module cond_negate_64b (
  input  logic        neg,
  input  logic [63:0] din,
  output logic [63:0] dout
);
  assign dout = neg ? (~din + 64'd1) : din;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one radix-2 step per clock,
// magnitudes in the loop and sign correction in a final FIX cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);
  import muldiv_pkg::*;

  muldiv_state_e    state, state_nxt;
  logic [63:0]      acc, acc_step;
  logic [WIDTH-1:0] mag;
  logic             is_div, neg_q, neg_r, dz;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dbz_q;

  logic             accept, is_div_in, signed_in, dz_in;
  logic             busy, run_step, fix_commit;
  logic [63:0]      a_abs64, b_abs64, res64, rem64;
  logic [32:0]      mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             unused_bits;

  assign is_div_in = bus.op[1];
  assign signed_in = ~bus.op[0];
  assign dz_in     = is_div_in && (bus.b == '0);
  assign accept    = (state == IDLE) && bus.start && !bus.flush;

  cond_negate_64b u_abs_a (.neg(signed_in & bus.a[WIDTH-1]), .din({{WIDTH{1'b0}}, bus.a}), .dout(a_abs64));
  cond_negate_64b u_abs_b (.neg(signed_in & bus.b[WIDTH-1]), .din({{WIDTH{1'b0}}, bus.b}), .dout(b_abs64));

  // Multiply adds into the top half then shifts right; divide shifts left and
  // keeps the trial subtraction only when it does not borrow.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + {1'b0, mag};
    div_sh   = acc[63:31];
    div_diff = div_sh - {1'b0, mag};
    if (is_div) begin
      acc_step = div_diff[32] ? {div_sh[31:0], acc[30:0], 1'b0}
                              : {div_diff[31:0], acc[30:0], 1'b1};
    end else begin
      acc_step = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};
    end
  end

  cond_negate_64b u_fix_res (.neg(neg_q), .din(is_div ? {{WIDTH{1'b0}}, acc[31:0]} : acc), .dout(res64));
  cond_negate_64b u_fix_rem (.neg(neg_r), .din({{WIDTH{1'b0}}, acc[63:32]}), .dout(rem64));

  assign res_hi      = is_div ? rem64[31:0] : res64[63:32];
  assign res_lo      = res64[31:0];
  assign unused_bits = ^{a_abs64[63:32], b_abs64[63:32], rem64[63:32]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = dz_in ? FIX : RUN;
      RUN:     if (bus.flush) state_nxt = IDLE;
               else if (cnt == CNT_W'(ITER - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    run_step   = (state == RUN) && !bus.flush;
    fix_commit = (state == FIX) && !bus.flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mag    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        acc    <= is_div_in ? {{WIDTH{1'b0}}, a_abs64[31:0]} : {{WIDTH{1'b0}}, b_abs64[31:0]};
        mag    <= is_div_in ? b_abs64[31:0] : a_abs64[31:0];
        is_div <= is_div_in;
        neg_q  <= signed_in & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        neg_r  <= signed_in & is_div_in & bus.a[WIDTH-1];
        dz     <= dz_in;
        cnt    <= '0;
        dbz_q  <= 1'b0;
      end else if (state == IDLE) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
      if (run_step) begin
        acc <= acc_step;
        cnt <= cnt + CNT_W'(1);
      end
      if (fix_commit) begin
        done_q <= 1'b1;
        if (dz) begin
          dbz_q <= 1'b1;
        end else begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.dbg_state   = state;
endmodule
